instr_fetch_unit: RTL and testbench

Fetch stage ahead of the processor control unit. It reads three consecutive bytes from the 8-bit synchronous program memory starting at the fetch PC and assembles them into one 24-bit command word. It presents that word to the decoder through a valid/ready handshake, advances the PC by 3 per consumed instruction, and redirects on jumps.

---
 rtl/instr_fetch_unit_if.sv | 37 +++
 rtl/instr_fetch_unit.sv | 97 +++++++++
 tb/tb_instr_fetch_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, its program memory and the decoder.
// Memory read port, command valid/ready handshake and jump redirect.
interface instr_fetch_unit_if;
  logic [7:0]  mem_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_data;
  logic [23:0] cmd_word;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  pc_out;
  logic        jmp_en;
  logic [7:0]  jmp_addr;

  modport master (
    output mem_addr,
    output mem_rd_en,
    input  mem_data,
    output cmd_word,
    output cmd_valid,
    input  cmd_ready,
    output pc_out,
    input  jmp_en,
    input  jmp_addr
  );

  modport slave (
    input  mem_addr,
    input  mem_rd_en,
    output mem_data,
    input  cmd_word,
    input  cmd_valid,
    output cmd_ready,
    input  pc_out,
    output jmp_en,
    output jmp_addr
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: reads three bytes from 8-bit synchronous program memory, assembles a
// 24-bit command word and hands it to the decoder over valid/ready; supports jumps.
module instr_fetch_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic                       clk,
  input  logic                       rst,
  instr_fetch_unit_if.master         fetch_if,
  output logic [2:0]                 state_out
);

  typedef enum logic [2:0] {
    StB0    = 3'd0,
    StB1    = 3'd1,
    StB2    = 3'd2,
    StCap   = 3'd3,
    StValid = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  fetch_pc_q, fetch_pc_d;
  logic [23:0] cmd_word_q, cmd_word_d;
  logic [7:0]  pc_out_q, pc_out_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StB0;
      fetch_pc_q <= RESET_PC;
      cmd_word_q <= 24'h0;
      pc_out_q   <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      cmd_word_q <= cmd_word_d;
      pc_out_q   <= pc_out_d;
    end
  end

  // Jump outranks sequencing; partial bytes are simply never completed.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    cmd_word_d = cmd_word_q;
    pc_out_d   = pc_out_q;
    if (fetch_if.jmp_en) begin
      state_d    = StB0;
      fetch_pc_d = fetch_if.jmp_addr;
    end else begin
      case (state_q)
        StB0: state_d = StB1;
        StB1: begin
          cmd_word_d[23:16] = fetch_if.mem_data;
          state_d           = StB2;
        end
        StB2: begin
          cmd_word_d[15:8] = fetch_if.mem_data;
          state_d          = StCap;
        end
        StCap: begin
          cmd_word_d[7:0] = fetch_if.mem_data;
          pc_out_d        = fetch_pc_q;
          state_d         = StValid;
        end
        StValid: begin
          if (fetch_if.cmd_ready) begin
            fetch_pc_d = fetch_pc_q + 8'd3;
            state_d    = StB0;
          end
        end
        default: state_d = StB0;
      endcase
    end
  end

  always_comb begin
    fetch_if.mem_rd_en = 1'b0;
    fetch_if.mem_addr  = fetch_pc_q;
    case (state_q)
      StB0: fetch_if.mem_rd_en = ~rst;
      StB1: begin
        fetch_if.mem_rd_en = ~rst;
        fetch_if.mem_addr  = fetch_pc_q + 8'd1;
      end
      StB2: begin
        fetch_if.mem_rd_en = ~rst;
        fetch_if.mem_addr  = fetch_pc_q + 8'd2;
      end
      default: ;
    endcase
  end

  assign fetch_if.cmd_valid = (state_q == StValid);
  assign fetch_if.cmd_word  = cmd_word_q;
  assign fetch_if.pc_out    = pc_out_q;
  assign state_out          = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a stimulus thread pushes expected words into a
// scoreboard queue and a negedge monitor pops and compares on every handshake.
module tb_instr_fetch_unit;

  logic       clk;
  logic       rst;
  logic [2:0] state_out;
  logic [7:0] mem [256];
  logic [31:0] exp_q [$];
  int vectors;
  int miscompares;
  int transfers;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .RESET_PC(8'h00)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .fetch_if (bus),
    .state_out(state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_data <= mem[bus.mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a transfer is an edge seeing valid & ready without reset.
  always @(negedge clk) begin
    if (!rst && bus.cmd_valid && bus.cmd_ready) begin
      transfers++;
      if (exp_q.size() == 0) begin
        check("unexpected_transfer", {8'h0, bus.cmd_word}, 32'hFFFF_FFFF);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("word", {8'h0, bus.cmd_word}, {8'h0, e[31:8]});
        check("pc_out", {24'h0, bus.pc_out}, {24'h0, e[7:0]});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    transfers = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h12; mem[8'h01] = 8'h34; mem[8'h02] = 8'h56;
    mem[8'h03] = 8'h78; mem[8'h04] = 8'h9A; mem[8'h05] = 8'hBC;
    mem[8'h40] = 8'hA1; mem[8'h41] = 8'hA2; mem[8'h42] = 8'hA3;
    mem[8'hFE] = 8'hAA; mem[8'hFF] = 8'hBB;
    mem[8'h10] = 8'hD1; mem[8'h11] = 8'hD2; mem[8'h12] = 8'hD3;
    rst = 1'b1;
    bus.cmd_ready = 1'b0;
    bus.jmp_en = 1'b0;
    bus.jmp_addr = 8'h00;

    // Reset and first fetch
    step(); step();
    check("rst_state", {29'h0, state_out}, 32'd0);
    check("rst_valid", {31'h0, bus.cmd_valid}, 32'd0);
    check("rst_rd_en", {31'h0, bus.mem_rd_en}, 32'd0);
    check("rst_word", {8'h0, bus.cmd_word}, 32'h0);
    check("rst_pc_out", {24'h0, bus.pc_out}, 32'h0);
    rst = 1'b0;
    exp_q.push_back({24'h123456, 8'h00});
    #1;
    check("b0_rd_en", {31'h0, bus.mem_rd_en}, 32'd1);
    check("b0_addr", {24'h0, bus.mem_addr}, 32'h00);
    step();
    check("b1_addr", {24'h0, bus.mem_addr}, 32'h01);
    step();
    check("b2_addr", {24'h0, bus.mem_addr}, 32'h02);
    step();
    check("cap_rd_en", {31'h0, bus.mem_rd_en}, 32'd0);
    check("cap_valid", {31'h0, bus.cmd_valid}, 32'd0);
    step();
    check("latency_valid", {31'h0, bus.cmd_valid}, 32'd1);

    // Backpressure: word must hold with no reads
    for (int i = 0; i < 6; i++) begin
      step();
      check("hold_valid", {31'h0, bus.cmd_valid}, 32'd1);
      check("hold_word", {8'h0, bus.cmd_word}, 32'h123456);
      check("hold_rd_en", {31'h0, bus.mem_rd_en}, 32'd0);
    end
    bus.cmd_ready = 1'b1;
    exp_q.push_back({24'h789ABC, 8'h03});
    step();
    bus.cmd_ready = 1'b0;
    check("post_hs_valid", {31'h0, bus.cmd_valid}, 32'd0);
    check("seq_addr3", {24'h0, bus.mem_addr}, 32'h03);
    step();
    check("seq_addr4", {24'h0, bus.mem_addr}, 32'h04);
    step();
    check("seq_addr5", {24'h0, bus.mem_addr}, 32'h05);
    step(); step();
    check("valid2", {31'h0, bus.cmd_valid}, 32'd1);
    bus.cmd_ready = 1'b1;
    step();
    bus.cmd_ready = 1'b0;

    // Jump mid-fetch from B2
    step(); step();
    check("in_b2", {29'h0, state_out}, 32'd2);
    bus.jmp_en = 1'b1;
    bus.jmp_addr = 8'h40;
    exp_q.push_back({24'hA1A2A3, 8'h40});
    step();
    bus.jmp_en = 1'b0;
    check("jmp_state", {29'h0, state_out}, 32'd0);
    check("jmp_addr", {24'h0, bus.mem_addr}, 32'h40);
    step(); step(); step(); step();
    check("jmp_valid", {31'h0, bus.cmd_valid}, 32'd1);
    bus.cmd_ready = 1'b1;
    step();
    bus.cmd_ready = 1'b0;

    // Wrap-around at the top of the address space
    mem[8'h00] = 8'hCC;
    bus.jmp_en = 1'b1;
    bus.jmp_addr = 8'hFE;
    exp_q.push_back({24'hAABBCC, 8'hFE});
    step();
    bus.jmp_en = 1'b0;
    check("wrap_addr_fe", {24'h0, bus.mem_addr}, 32'hFE);
    step();
    check("wrap_addr_ff", {24'h0, bus.mem_addr}, 32'hFF);
    step();
    check("wrap_addr_00", {24'h0, bus.mem_addr}, 32'h00);
    step(); step();
    bus.cmd_ready = 1'b1;
    exp_q.push_back({24'h345678, 8'h01});
    step();
    bus.cmd_ready = 1'b0;
    check("wrap_next_pc", {24'h0, bus.mem_addr}, 32'h01);

    // Jump coincident with handshake
    step(); step(); step(); step();
    check("coinc_valid", {31'h0, bus.cmd_valid}, 32'd1);
    bus.cmd_ready = 1'b1;
    bus.jmp_en = 1'b1;
    bus.jmp_addr = 8'h10;
    step();
    bus.cmd_ready = 1'b0;
    bus.jmp_en = 1'b0;
    check("coinc_addr", {24'h0, bus.mem_addr}, 32'h10);
    check("coinc_valid_low", {31'h0, bus.cmd_valid}, 32'd0);

    // Reset during VALID drops the held word
    step(); step(); step(); step();
    check("pre_rst_word", {8'h0, bus.cmd_word}, 32'hD1D2D3);
    rst = 1'b1;
    step();
    check("rstv_valid", {31'h0, bus.cmd_valid}, 32'd0);
    check("rstv_word", {8'h0, bus.cmd_word}, 32'h0);
    check("rstv_rd_en", {31'h0, bus.mem_rd_en}, 32'd0);
    rst = 1'b0;
    #1;
    check("rstv_restart", {24'h0, bus.mem_addr}, 32'h00);
    check("rstv_restart_en", {31'h0, bus.mem_rd_en}, 32'd1);
    step(); step();

    check("transfers", transfers, 32'd5);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
